// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead group per cycle, plus word-level G/P.
// Latency: done pulses N=WIDTH/4 cycles after the accepted start edge; one add every N+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Optional feature: define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
// WIDTH must be a multiple of 4 and at least 4.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             g_out,
`ifdef CLA_SEQ_OVF_EN
  output logic             p_out,
  output logic             ovf
`else
  output logic             p_out
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             g_acc;
  logic             p_acc;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3, c4;
  logic       gg, pg;
  logic [3:0] sum_nib;
  logic       last;

  // Lookahead for the group selected by idx, from the captured operands and the running carry.
  always_comb begin
    a_nib   = 4'(a_r >> {idx, 2'b00});
    b_nib   = 4'(b_r >> {idx, 2'b00});
    g       = a_nib & b_nib;
    p       = a_nib ^ b_nib;
    c1      = g[0] | (p[0] & carry);
    c2      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4      = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry);
    gg      = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg      = &p;
    sum_nib = p ^ {c3, c2, c1, carry};
    last    = (idx == IW'(N - 1));
  end

  // Control FSM and all registered outputs; reset mid-add discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      g_acc <= 1'b0;
      p_acc <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      g_out <= 1'b0;
      p_out <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_r   <= a;
            b_r   <= b;
            idx   <= '0;
            carry <= cin;
            g_acc <= 1'b0;
            p_acc <= 1'b1;
            sum   <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          // sum was cleared on start, so OR-ing each nibble into place is enough.
          sum   <= sum | (WIDTH'(sum_nib) << {idx, 2'b00});
          carry <= c4;
          g_acc <= gg | (pg & g_acc);
          p_acc <= p_acc & pg;
          idx   <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            cout  <= c4;
            g_out <= gg | (pg & g_acc);
            p_out <= p_acc & pg;
`ifdef CLA_SEQ_OVF_EN
            ovf   <= c3 ^ c4;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: driver pushes model results, monitor checks on done.
// Reference model is plain integer arithmetic on the full word.
module tb_cla_seq_adder;
`ifdef CLA_SEQ_OVF_EN
  localparam int W = 16;
`else
  localparam int W = 8;
`endif
  localparam int N = W / 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         g;
    logic         p;
    logic         ovf;
    logic         cin;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, g_out, p_out;
  logic [W-1:0] sum;
  logic         ovf;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .g_out (g_out),
`ifdef CLA_SEQ_OVF_EN
    .p_out (p_out),
    .ovf   (ovf)
`else
    .p_out (p_out)
`endif
  );

`ifndef CLA_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t e;
    logic [W:0] full;
    logic [W:0] nocarry;
    full    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    nocarry = {1'b0, av} + {1'b0, bv};
    e.sum   = full[W-1:0];
    e.cout  = full[W];
    e.g     = nocarry[W];
    e.p     = ((av ^ bv) == {W{1'b1}});
    e.ovf   = (av[W-1] == bv[W-1]) && (e.sum[W-1] != av[W-1]);
    e.cin   = cv;
    e.cyc   = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("sum", sum, m_e.sum);
        chk("cout", cout, m_e.cout);
        chk("g_out", g_out, m_e.g);
        chk("p_out", p_out, m_e.p);
        chk("done_cycle", cyc, m_e.cyc);
        chk("busy_at_done", busy, 1);
        chk("cout_vs_gp", cout, g_out | (p_out & m_e.cin));
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", ovf, m_e.ovf);
`endif
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  // Issue one add, keeping start high for 'hold' edges; operands are scrambled after capture.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input int hold, input bit do_busy_chk);
    exp_t e;
    wait_idle();
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    e = model(av, bv, cv);
    e.cyc = cyc + 1 + N;
    q.push_back(e);
    @(posedge clk);
    #1;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    if (hold > 1) repeat (hold - 1) @(posedge clk);
    #1;
    start = 1'b0;
    if (do_busy_chk) begin
      @(negedge clk);
      if (q.size() != 0) chk("busy_in_run", busy, 1);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_g"}, g_out, 0);
    chk({tag, "_p"}, p_out, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_cleared("post_reset");

`ifdef CLA_SEQ_OVF_EN
    issue(16'h7FFF, 16'h0001, 1'b0, 1, 1'b1); drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0); drain();
    issue(16'h8000, 16'h8000, 1'b0, 1, 1'b0); drain();
    issue(16'h7FFF, 16'h0000, 1'b1, 1, 1'b0); drain();
`else
    issue(8'h0F, 8'h01, 1'b0, 1, 1'b1); drain();
    issue(8'hFF, 8'h01, 1'b0, 1, 1'b0); drain();
    issue(8'hFF, 8'h00, 1'b1, 1, 1'b0); drain();
    issue(8'hFF, 8'h00, 1'b0, 1, 1'b0); drain();
`endif

    // start held for 4 edges: only one add is accepted.
    issue(W'(8'h12), W'(8'h34), 1'b0, 4, 1'b1);
    drain();
    repeat (4) @(negedge clk);

    // Reset pulsed on the edge after the start edge: no result, no done.
    wait_idle();
    a = W'(8'hAA);
    b = W'(8'h55);
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_cleared("abort");
    repeat (2 * N + 4) @(negedge clk);
    chk("abort_no_done_busy", busy, 0);
    issue(W'(8'h01), W'(8'h01), 1'b0, 1, 1'b0);
    drain();

    // Random adds, including back-to-back issue as soon as the DUT is idle.
    for (int i = 0; i < ((W == 16) ? 1000 : 300); i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1, 1'b0);
      if ((i % 7) == 0) drain();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
